uart_rx_word: RTL and testbench

- Serial 8N1 UART receiver. Sits directly downstream of message_mode: its rxd input is driven by message_mode's txd line.
- Recovers each transmitted character, presents it on a parallel bus with a one-cycle valid strobe, and keeps a running character count.
- The count lets the board-level loopback check that the full message arrived.

---
 rtl/uart_rx_word.sv | 120 ++++++++++++
 tb/tb_uart_rx_word.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from the detected start edge,
// parallel word with one-cycle valid strobe, framing-error strobe and running good-byte count.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    output logic [7:0]       word,
    output logic             word_valid,
    output logic             frame_error,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy
);

    localparam int          HALF      = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]  state;
    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        rx_p0;
    logic        rx_p1;
    logic        rx_s;

    assign rx_s = rx_p1;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0       <= 1'b1;
            rx_p1       <= 1'b1;
            state       <= S_IDLE;
            baud        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            word        <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            byte_count  <= '0;
        end else begin
            // stage p0/p1: metastability synchronizer for the asynchronous line
            rx_p0       <= rxd;
            rx_p1       <= rx_p0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        baud  <= '0;
                    end
                end
                S_START: begin
                    if (baud == HALF_LAST) begin
                        baud <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud == BIT_LAST) begin
                        baud           <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud == BIT_LAST) begin
                        baud <= '0;
                        if (rx_s) begin
                            word       <= shreg;
                            word_valid <= 1'b1;
                            byte_count <= byte_count + CNT_W'(1);
                            state      <= S_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= S_WAIT;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_WAIT: begin
                    // a held-low line (break) reports once, then waits for idle
                    if (rx_s) begin
                        state <= S_IDLE;
                        baud  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit; a second instance with a 3-bit
// counter shares the line so count wrap-around is exercised within a short run.
module tb_uart_rx_word;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] word;
    logic       word_valid;
    logic       frame_error;
    logic [9:0] byte_count;
    logic       busy;
    logic [7:0] word2;
    logic       wv2;
    logic       fe2;
    logic [2:0] bc2;
    logic       busy2;

    uart_rx_word #(.CLKS_PER_BIT(N), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .word(word), .word_valid(word_valid),
        .frame_error(frame_error), .byte_count(byte_count), .busy(busy)
    );

    uart_rx_word #(.CLKS_PER_BIT(N), .CNT_W(3)) dut_w3 (
        .clk(clk), .rst(rst), .rxd(rxd), .word(word2), .word_valid(wv2),
        .frame_error(fe2), .byte_count(bc2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] vq[$];
    int         cq[$];
    int         fe_cnt   = 0;
    int         both_cnt = 0;
    int         fe2_cnt  = 0;
    int         wv2_cnt  = 0;

    always @(negedge clk) begin
        if (word_valid) begin
            vq.push_back(word);
            cq.push_back(cyc);
        end
        if (frame_error) fe_cnt++;
        if (word_valid && frame_error) both_cnt++;
        if (fe2) fe2_cnt++;
        if (wv2) wv2_cnt++;
    end

    int n_vec  = 0;
    int n_fail = 0;
    int last_start;
    logic [7:0] model_word = 8'h00;
    int         model_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int jit);
        last_start = cyc;
        drive(1'b0, N + jit);
        for (int i = 0; i < 8; i++) drive(d[i], N);
        drive(stop, N - jit);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_word"}, 32'(word), 32'(model_word));
        chk({tag, "_count"}, 32'(byte_count), 32'(model_cnt));
        chk({tag, "_count_w3"}, 32'(bc2), 32'(model_cnt % 8));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]        data;
        logic              stop;
        logic signed [7:0] jit;
        logic              exp_valid;
        logic              exp_fe;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n0;
        int fe0;

        vecs[0] = '{8'hA5, 1'b1,  8'sd0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1,  8'sd0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1,  8'sd0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1,  8'sd0, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1,  8'sd0, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b1,  8'sd3, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b1, -8'sd3, 1'b1, 1'b0};
        vecs[7] = '{8'hAA, 1'b0,  8'sd0, 1'b0, 1'b1};
        vecs[8] = '{8'h5A, 1'b1,  8'sd0, 1'b1, 1'b0};

        // reset held with the line toggling
        rst = 1'b0;
        rxd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rxd = ~rxd;
        end
        chk("rst_word", 32'(word), 32'h0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_fe", 32'(frame_error), 32'h0);
        chk("rst_count", 32'(byte_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rxd = 1'b1;
        rst = 1'b1;
        drive(1'b1, 100);
        chk("idle_pulses", 32'(vq.size() + fe_cnt), 32'h0);
        chk_state("idle");

        // table of single frames
        for (int v = 0; v < 9; v++) begin
            n0  = vq.size();
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop, int'(vecs[v].jit));
            drive(1'b1, 24);
            chk($sformatf("v%0d_valid_cnt", v), 32'(vq.size() - n0), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_fe_cnt", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
            if (vecs[v].exp_valid && vq.size() > n0) begin
                chk($sformatf("v%0d_pulse_word", v), 32'(vq[n0]), 32'(vecs[v].data));
                chk($sformatf("v%0d_latency", v), 32'(cq[n0] - last_start), 32'd155);
            end
            if (vecs[v].exp_valid) begin
                model_word = vecs[v].data;
                model_cnt++;
            end
            chk_state($sformatf("v%0d", v));
        end

        // back-to-back "Hi\n"
        begin
            int s0;
            n0 = vq.size();
            s0 = cyc;
            send_frame(8'h48, 1'b1, 0);
            send_frame(8'h69, 1'b1, 0);
            send_frame(8'h0A, 1'b1, 0);
            drive(1'b1, 24);
            chk("b2b_cnt", 32'(vq.size() - n0), 32'd3);
            if (vq.size() >= n0 + 3) begin
                chk("b2b_w0", 32'(vq[n0]), 32'h48);
                chk("b2b_w1", 32'(vq[n0+1]), 32'h69);
                chk("b2b_w2", 32'(vq[n0+2]), 32'h0A);
                chk("b2b_lat", 32'(cq[n0] - s0), 32'd155);
                chk("b2b_gap1", 32'(cq[n0+1] - cq[n0]), 32'd160);
                chk("b2b_gap2", 32'(cq[n0+2] - cq[n0+1]), 32'd160);
            end
            model_word = 8'h0A;
            model_cnt += 3;
            chk_state("b2b");
        end

        // start-bit glitch
        n0  = vq.size();
        fe0 = fe_cnt;
        drive(1'b0, 4);
        chk("glitch_busy", 32'(busy), 32'd1);
        drive(1'b1, 40);
        chk("glitch_pulses", 32'(vq.size() - n0 + fe_cnt - fe0), 32'd0);
        chk_state("glitch");
        send_frame(8'h55, 1'b1, 0);
        drive(1'b1, 24);
        chk("after_glitch_cnt", 32'(vq.size() - n0), 32'd1);
        model_word = 8'h55;
        model_cnt++;
        chk_state("after_glitch");

        // framing error followed by a long break
        n0  = vq.size();
        fe0 = fe_cnt;
        send_frame(8'hFF, 1'b0, 0);
        drive(1'b0, 300);
        chk("break_busy", 32'(busy), 32'd1);
        drive(1'b1, 24);
        chk("break_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
        chk("break_valid_cnt", 32'(vq.size() - n0), 32'd0);
        chk_state("break");
        send_frame(8'h31, 1'b1, 0);
        drive(1'b1, 24);
        chk("after_break_cnt", 32'(vq.size() - n0), 32'd1);
        model_word = 8'h31;
        model_cnt++;
        chk_state("after_break");
        chk("both_high", 32'(both_cnt), 32'd0);
        chk("w3_word", 32'(word2), 32'(model_word));
        chk("w3_valid_total", 32'(wv2_cnt), 32'(model_cnt));
        chk("w3_fe_total", 32'(fe2_cnt), 32'(fe_cnt));

        // reset in the middle of a frame carrying 8'hF0
        n0  = vq.size();
        fe0 = fe_cnt;
        drive(1'b0, N);
        drive(1'b0, 4 * N);
        chk("abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        rxd = 1'b1;
        #1;
        chk("abort_async_busy", 32'(busy), 32'd0);
        chk("abort_async_count", 32'(byte_count), 32'd0);
        model_word = 8'h00;
        model_cnt  = 0;
        drive(1'b1, 3);
        rst = 1'b1;
        drive(1'b1, 200);
        chk("abort_pulses", 32'(vq.size() - n0 + fe_cnt - fe0), 32'd0);
        chk_state("abort");
        send_frame(8'h42, 1'b1, 0);
        drive(1'b1, 24);
        model_word = 8'h42;
        model_cnt  = 1;
        chk_state("after_abort");
        chk("busy_match", 32'(busy2), 32'(busy));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
